// File: rtl/marx_lock_alloc_pkg.sv
// Shared types and helpers for the MARX lock allocator: assignment-ID width and per-stage state.
package marx_lock_alloc_pkg;

    // Widest requester ID the stage state can hold.
    localparam int ID_W_MAX = 8;

    function automatic int assid_width(input int nin);
        return (nin > 1) ? $clog2(nin) : 1;
    endfunction

    typedef struct packed {
        logic [ID_W_MAX-1:0] ptr;
        logic [ID_W_MAX-1:0] owner;
        logic                locked;
    } stage_state_t;

endpackage

// File: rtl/marx_lock_allocator_if.sv
// Request/grant bundle between the MARX core request ports and the lock allocator.
interface marx_lock_allocator_if
    import marx_lock_alloc_pkg::*;
#(
    parameter int NIN  = 4,
    parameter int NOUT = 2
);
    localparam int NIN2 = assid_width(NIN);

    logic [NIN-1:0]       req_di;
    logic [NIN-1:0]       lock_di;
    logic [NOUT-1:0]      avail_di;
    logic [NIN-1:0]       ack_do;
    logic [NOUT-1:0]      alloc_do;
    logic [NOUT*NIN2-1:0] assid_do;
    logic [NOUT-1:0]      locked_do;

    modport master (
        output req_di, lock_di, avail_di,
        input  ack_do, alloc_do, assid_do, locked_do
    );

    modport slave (
        input  req_di, lock_di, avail_di,
        output ack_do, alloc_do, assid_do, locked_do
    );
endinterface

// File: rtl/firstone_arbiter.sv
// Lowest-index set-bit finder shared by the allocator stages.
module firstone_arbiter
    import marx_lock_alloc_pkg::*;
#(
    parameter int N = 4,
    parameter int W = assid_width(N)
) (
    input  logic [N-1:0] vec,
    output logic         found,
    output logic [W-1:0] idx
);

    // Scan high to low so the lowest set bit is the last writer.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = vec[i] ? W'(i) : idx;
        end
    end

    assign found = |vec;

endmodule

// File: rtl/marx_lock_alloc_stage.sv
// One round-robin allocation stage per resource: rotate/mask search, lock entry/exit, state registers.
module marx_lock_alloc_stage
    import marx_lock_alloc_pkg::*;
#(
    parameter int NIN  = 4,
    parameter int NIN2 = assid_width(NIN)
) (
    input  logic            clk_ci,
    input  logic            rst_rbi,
    input  logic [NIN-1:0]  req,
    input  logic [NIN-1:0]  lock,
    input  logic [NIN-1:0]  starved,
    input  logic [NIN-1:0]  exclude,
    input  logic            avail,
    output logic            alloc,
    output logic [NIN2-1:0] assid,
    output logic [NIN-1:0]  grant_oh,
    output logic [NIN-1:0]  owner_oh,
    output logic [NIN-1:0]  mask_down,
    output logic            locked
);

    stage_state_t    state_r;
    stage_state_t    state_s;
    logic [NIN-1:0]  cand_s;
    logic [NIN-1:0]  hungry_s;
    logic [NIN-1:0]  search_s;
    logic [NIN-1:0]  upper_s;
    logic [NIN-1:0]  own_s;
    logic            up_found_s;
    logic            lo_found_s;
    logic [NIN2-1:0] up_idx_s;
    logic [NIN2-1:0] lo_idx_s;
    logic [NIN2-1:0] win_s;
    logic            owner_req_s;
    logic            owner_lock_s;
    logic            win_lock_s;

    assign cand_s   = req & ~exclude;
    assign hungry_s = cand_s & starved;
    assign search_s = (|hungry_s) ? hungry_s : cand_s;

    // Split the search at the pointer and decode the owner one-hot.
    always_comb begin
        upper_s = '0;
        own_s   = '0;
        for (int i = 0; i < NIN; i++) begin
            upper_s[i] = search_s[i] & (ID_W_MAX'(i) > state_r.ptr);
            own_s[i]   = (ID_W_MAX'(i) == state_r.owner);
        end
    end

    firstone_arbiter #(.N(NIN), .W(NIN2)) u_upper (
        .vec   (upper_s),
        .found (up_found_s),
        .idx   (up_idx_s)
    );

    firstone_arbiter #(.N(NIN), .W(NIN2)) u_lower (
        .vec   (search_s),
        .found (lo_found_s),
        .idx   (lo_idx_s)
    );

    assign win_s        = up_found_s ? up_idx_s : lo_idx_s;
    assign owner_req_s  = |(req & own_s);
    assign owner_lock_s = |(lock & own_s);
    assign win_lock_s   = |(lock & grant_oh);

    // Grant outputs: a locked resource only ever serves its owner.
    always_comb begin
        alloc    = 1'b0;
        assid    = state_r.ptr[NIN2-1:0];
        grant_oh = '0;
        if (state_r.locked) begin
            alloc = avail & owner_req_s;
            assid = state_r.owner[NIN2-1:0];
        end else begin
            alloc = avail & lo_found_s;
            assid = lo_found_s ? win_s : state_r.ptr[NIN2-1:0];
        end
        for (int i = 0; i < NIN; i++) begin
            grant_oh[i] = alloc & (assid == NIN2'(i));
        end
    end

    assign mask_down = exclude | grant_oh;
    assign owner_oh  = state_r.locked ? own_s : '0;
    assign locked    = state_r.locked;

    // Next state: pointer moves only on a real grant; releasing a lock parks the pointer on the owner.
    always_comb begin
        state_s = state_r;
        if (state_r.locked) begin
            if (alloc | ~owner_lock_s) begin
                state_s.ptr = state_r.owner;
            end else begin
                state_s.ptr = state_r.ptr;
            end
            state_s.locked = owner_lock_s;
        end else begin
            if (alloc) begin
                state_s.ptr    = ID_W_MAX'(win_s);
                state_s.locked = win_lock_s;
                state_s.owner  = win_lock_s ? ID_W_MAX'(win_s) : state_r.owner;
            end else begin
                state_s = state_r;
            end
        end
    end

    // Stage state register; reset drops any lock at once.
    always_ff @(posedge clk_ci or negedge rst_rbi) begin
        if (!rst_rbi) begin
            state_r <= '0;
        end else begin
            state_r <= state_s;
        end
    end

endmodule

// File: rtl/marx_lock_allocator.sv
// MARX lock allocator top: mask cascade, owner mask, ack reduction and optional aging.
// Anti-starvation aging is compiled in with `define MARX_LOCK_ALLOC_AGING_EN.
module marx_lock_allocator
    import marx_lock_alloc_pkg::*;
#(
    parameter int NIN     = 4,
    parameter int NOUT    = 2,
    parameter int AGE_MAX = 7
) (
    input logic                  clk_ci,
    input logic                  rst_rbi,
    marx_lock_allocator_if.slave bus
);

    localparam int NIN2 = assid_width(NIN);

    if (NIN < 2)     begin : g_nin_chk  $error("marx_lock_allocator: NIN must be >= 2");     end
    if (NOUT < 1)    begin : g_nout_chk $error("marx_lock_allocator: NOUT must be >= 1");    end
    if (AGE_MAX < 1) begin : g_age_chk  $error("marx_lock_allocator: AGE_MAX must be >= 1"); end

    logic [NIN-1:0]       owner_mask_s;
    logic [NIN-1:0]       starved_s;
    logic [NIN-1:0]       ack_s;
    logic [NIN-1:0]       grant_oh_s [NOUT];
    logic [NIN-1:0]       owner_oh_s [NOUT];
    logic [NOUT-1:0]      alloc_s;
    logic [NOUT-1:0]      locked_s;
    logic [NOUT*NIN2-1:0] assid_s;

    for (genvar j = 0; j < NOUT; j++) begin : g_stage
        logic [NIN-1:0] mask_up_s;
        logic [NIN-1:0] mask_down_s;

        if (j == 0) begin : g_head
            assign mask_up_s = '0;
        end else begin : g_tail
            assign mask_up_s = g_stage[j-1].mask_down_s;
        end

        marx_lock_alloc_stage #(.NIN(NIN), .NIN2(NIN2)) u_stage (
            .clk_ci    (clk_ci),
            .rst_rbi   (rst_rbi),
            .req       (bus.req_di),
            .lock      (bus.lock_di),
            .starved   (starved_s),
            .exclude   (mask_up_s | owner_mask_s),
            .avail     (bus.avail_di[j]),
            .alloc     (alloc_s[j]),
            .assid     (assid_s[j*NIN2 +: NIN2]),
            .grant_oh  (grant_oh_s[j]),
            .owner_oh  (owner_oh_s[j]),
            .mask_down (mask_down_s),
            .locked    (locked_s[j])
        );
    end

    // Owners of locked resources are hidden from every unlocked stage; acks gather all grants.
    always_comb begin
        owner_mask_s = '0;
        ack_s        = '0;
        for (int j = 0; j < NOUT; j++) begin
            owner_mask_s = owner_mask_s | owner_oh_s[j];
            ack_s        = ack_s | grant_oh_s[j];
        end
    end

`ifdef MARX_LOCK_ALLOC_AGING_EN
    localparam int WAIT_W = $clog2(AGE_MAX + 1);

    logic [WAIT_W-1:0] wait_r [NIN];

    // Count consecutive refused cycles per requester, saturating at AGE_MAX.
    always_ff @(posedge clk_ci or negedge rst_rbi) begin
        if (!rst_rbi) begin
            for (int i = 0; i < NIN; i++) begin
                wait_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NIN; i++) begin
                if (bus.req_di[i] & ~ack_s[i]) begin
                    wait_r[i] <= (wait_r[i] == WAIT_W'(AGE_MAX)) ? wait_r[i] : wait_r[i] + WAIT_W'(1);
                end else begin
                    wait_r[i] <= '0;
                end
            end
        end
    end

    // Starved flags feed the priority filter in every unlocked stage.
    always_comb begin
        starved_s = '0;
        for (int i = 0; i < NIN; i++) begin
            starved_s[i] = (wait_r[i] == WAIT_W'(AGE_MAX));
        end
    end
`else
    assign starved_s = '0;
`endif

    assign bus.ack_do    = ack_s;
    assign bus.alloc_do  = alloc_s;
    assign bus.assid_do  = assid_s;
    assign bus.locked_do = locked_s;

endmodule

// File: tb/tb_marx_lock_allocator.sv
// Directed, table-driven bench for marx_lock_allocator (NIN=4/NOUT=2 and NIN=3/NOUT=1 instances).
module tb_marx_lock_allocator;

    logic clk_ci  = 1'b0;
    logic rst_rbi = 1'b0;
    int   n_cmp   = 0;
    int   n_fail  = 0;

    always #5 clk_ci = ~clk_ci;

    marx_lock_allocator_if #(.NIN(4), .NOUT(2)) bus_a ();
    marx_lock_allocator_if #(.NIN(3), .NOUT(1)) bus_b ();

    marx_lock_allocator #(.NIN(4), .NOUT(2), .AGE_MAX(2)) dut_a (
        .clk_ci  (clk_ci),
        .rst_rbi (rst_rbi),
        .bus     (bus_a)
    );

    marx_lock_allocator #(.NIN(3), .NOUT(1), .AGE_MAX(2)) dut_b (
        .clk_ci  (clk_ci),
        .rst_rbi (rst_rbi),
        .bus     (bus_b)
    );

    typedef struct {
        logic [3:0] req;
        logic [3:0] lock;
        logic [1:0] avail;
        logic [3:0] ack;
        logic [1:0] alloc;
        logic [3:0] assid;
        logic [1:0] locked;
    } vec_t;

    localparam int NV = 18;
    vec_t vt [NV];

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %b, expected %b", nm, idx, act, exp);
        end
    endtask

    task automatic drive_a(input logic [3:0] r, input logic [3:0] l, input logic [1:0] a);
        bus_a.req_di   = r;
        bus_a.lock_di  = l;
        bus_a.avail_di = a;
    endtask

    task automatic check_a(input string nm, input int idx, input logic [3:0] ack,
                           input logic [1:0] alloc, input logic [3:0] assid, input logic [1:0] locked);
        chk({nm, ".ack"},    idx, {4'b0000, bus_a.ack_do},    {4'b0000, ack});
        chk({nm, ".alloc"},  idx, {6'b000000, bus_a.alloc_do}, {6'b000000, alloc});
        chk({nm, ".assid"},  idx, {4'b0000, bus_a.assid_do},  {4'b0000, assid});
        chk({nm, ".locked"}, idx, {6'b000000, bus_a.locked_do}, {6'b000000, locked});
    endtask

    initial begin
        logic [3:0] age_ack;
        logic [3:0] age_assid;
        logic [1:0] b_ids [6];
        logic [2:0] b_ack;

        //            req      lock     avail  ack      alloc  assid    locked
        vt[0]  = '{4'b1111, 4'b0000, 2'b11, 4'b0110, 2'b11, 4'b1001, 2'b00};
        vt[1]  = '{4'b1111, 4'b0000, 2'b11, 4'b1100, 2'b11, 4'b1110, 2'b00};
        vt[2]  = '{4'b1111, 4'b0000, 2'b11, 4'b1001, 2'b11, 4'b0011, 2'b00};
        vt[3]  = '{4'b1111, 4'b0000, 2'b11, 4'b0011, 2'b11, 4'b0100, 2'b00};
        vt[4]  = '{4'b1111, 4'b0000, 2'b00, 4'b0000, 2'b00, 4'b1001, 2'b00};
        vt[5]  = '{4'b1111, 4'b0000, 2'b00, 4'b0000, 2'b00, 4'b1001, 2'b00};
        vt[6]  = '{4'b1111, 4'b0000, 2'b00, 4'b0000, 2'b00, 4'b1001, 2'b00};
        vt[7]  = '{4'b1111, 4'b0000, 2'b01, 4'b0010, 2'b01, 4'b1001, 2'b00};
        vt[8]  = '{4'b1111, 4'b0000, 2'b10, 4'b0100, 2'b10, 4'b1010, 2'b00};
        vt[9]  = '{4'b0000, 4'b0000, 2'b11, 4'b0000, 2'b00, 4'b1001, 2'b00};
        vt[10] = '{4'b0100, 4'b0100, 2'b11, 4'b0100, 2'b01, 4'b1010, 2'b00};
        vt[11] = '{4'b1111, 4'b0100, 2'b11, 4'b1100, 2'b11, 4'b1110, 2'b01};
        vt[12] = '{4'b1111, 4'b0100, 2'b11, 4'b0101, 2'b11, 4'b0010, 2'b01};
        vt[13] = '{4'b1111, 4'b0100, 2'b11, 4'b0110, 2'b11, 4'b0110, 2'b01};
        vt[14] = '{4'b1111, 4'b0100, 2'b11, 4'b1100, 2'b11, 4'b1110, 2'b01};
        vt[15] = '{4'b1011, 4'b0100, 2'b11, 4'b0001, 2'b10, 4'b0010, 2'b01};
        vt[16] = '{4'b1111, 4'b0000, 2'b11, 4'b0110, 2'b11, 4'b0110, 2'b01};
        vt[17] = '{4'b1111, 4'b0000, 2'b11, 4'b1100, 2'b11, 4'b1011, 2'b00};

        drive_a(4'b0000, 4'b0000, 2'b00);
        bus_b.req_di   = 3'b000;
        bus_b.lock_di  = 3'b000;
        bus_b.avail_di = 1'b0;

        // Reset state of both instances.
        @(negedge clk_ci);
        #1;
        check_a("reset", 0, 4'b0000, 2'b00, 4'b0000, 2'b00);
        chk("reset_b.ack",   0, {5'b00000, bus_b.ack_do},   8'h00);
        chk("reset_b.assid", 0, {6'b000000, bus_b.assid_do}, 8'h00);
        rst_rbi = 1'b1;

        // Round-robin, pointer hold, idle and lock vectors.
        for (int k = 0; k < NV; k++) begin
            @(negedge clk_ci);
            drive_a(vt[k].req, vt[k].lock, vt[k].avail);
            #1;
            check_a("vec", k, vt[k].ack, vt[k].alloc, vt[k].assid, vt[k].locked);
        end

        // Lock both resources, then reset mid-lock.
        @(negedge clk_ci);
        drive_a(4'b0011, 4'b0011, 2'b11);
        #1;
        check_a("rstlock", 0, 4'b0011, 2'b11, 4'b0100, 2'b00);
        @(negedge clk_ci);
        #1;
        check_a("rstlock", 1, 4'b0011, 2'b11, 4'b0100, 2'b11);
        #1;
        rst_rbi = 1'b0;
        drive_a(4'b0000, 4'b0000, 2'b11);
        #1;
        check_a("rstlock", 2, 4'b0000, 2'b00, 4'b0000, 2'b00);
        @(negedge clk_ci);
        rst_rbi = 1'b1;
        drive_a(4'b1000, 4'b0000, 2'b11);
        #1;
        check_a("rstlock", 3, 4'b1000, 2'b01, 4'b0011, 2'b00);

        // Aging: ID 3 waits behind two locks, then competes in the first free cycle.
        @(negedge clk_ci);
        rst_rbi = 1'b0;
        drive_a(4'b0000, 4'b0000, 2'b00);
        #2;
        rst_rbi = 1'b1;
        @(negedge clk_ci);
        drive_a(4'b0011, 4'b0011, 2'b11);
        #1;
        check_a("age", 0, 4'b0011, 2'b11, 4'b0001, 2'b00);
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk_ci);
            drive_a(4'b1011, 4'b0011, 2'b11);
            #1;
            check_a("age", k, 4'b0011, 2'b11, 4'b0001, 2'b11);
        end
        @(negedge clk_ci);
        drive_a(4'b1011, 4'b0000, 2'b11);
        #1;
        check_a("age", 3, 4'b0011, 2'b11, 4'b0001, 2'b11);
`ifdef MARX_LOCK_ALLOC_AGING_EN
        age_ack   = 4'b1010;
        age_assid = 4'b0111;
`else
        age_ack   = 4'b0110;
        age_assid = 4'b0110;
`endif
        @(negedge clk_ci);
        drive_a(4'b1111, 4'b0000, 2'b11);
        #1;
        check_a("age", 4, age_ack, 2'b11, age_assid, 2'b00);
        drive_a(4'b0000, 4'b0000, 2'b00);

        // Single resource, three requesters: plain rotation 1,2,0,1,2,0.
        b_ids = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_ci);
            bus_b.req_di   = 3'b111;
            bus_b.avail_di = 1'b1;
            #1;
            b_ack = 3'b000;
            b_ack[b_ids[k]] = 1'b1;
            chk("nout1.assid", k, {6'b000000, bus_b.assid_do}, {6'b000000, b_ids[k]});
            chk("nout1.ack",   k, {5'b00000, bus_b.ack_do},    {5'b00000, b_ack});
            chk("nout1.alloc", k, {7'b0000000, bus_b.alloc_do}, 8'h01);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
